// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one data-memory transaction in flight, store lane
// alignment, load extraction/extension, misalignment trap and timeout abort.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic        wb_load,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_DEF = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic          st_q, st_d;
  logic [2:0]    ltype_q, ltype_d;
  logic [1:0]    stype_q, stype_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wbdata_q, wbdata_d;
  logic          bus_err_q, bus_err_d;

  logic        accept, st_mis, ld_mis, rvalid_eff, tmo;
  logic [31:0] sel, load_ext, lane_wdata;
  logic [3:0]  lane_be;

  always_comb begin
    accept     = req_valid && (state_q == S_IDLE);
    st_mis     = (mem_store_type == ST_SH) ? addr[0] :
                 (mem_store_type == ST_SB) ? 1'b0 : (addr[1:0] != 2'b00);
    ld_mis     = (mem_load_type == LT_LB || mem_load_type == LT_LBU) ? 1'b0 :
                 (mem_load_type == LT_LH || mem_load_type == LT_LHU) ? addr[0] :
                 (addr[1:0] != 2'b00);
    // A response owed to an aborted load must never complete a later op.
    rvalid_eff = dmem_rvalid && !drop_q;
    tmo        = (cnt_q == CNT_LAST);

    sel = dmem_rdata >> {addr_q[1:0], 3'b000};
    case (ltype_q)
      LT_LB:   load_ext = {{24{sel[7]}}, sel[7:0]};
      LT_LH:   load_ext = {{16{sel[15]}}, sel[15:0]};
      LT_LBU:  load_ext = {24'b0, sel[7:0]};
      LT_LHU:  load_ext = {16'b0, sel[15:0]};
      default: load_ext = dmem_rdata;
    endcase

    case (stype_q)
      ST_SB: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{data_q[7:0]}};
      end
      ST_SH: begin
        lane_be    = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{data_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = data_q;
      end
    endcase

    state_d   = state_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    st_d      = st_q;
    ltype_d   = ltype_q;
    stype_d   = stype_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    wbdata_d  = wbdata_q;
    bus_err_d = 1'b0;

    if (dmem_rvalid && drop_q) drop_d = 1'b0;

    if (accept) begin
      st_d    = mem_write;
      ltype_d = mem_load_type;
      stype_d = mem_store_type;
      addr_d  = addr;
      data_d  = store_data;
      rd_d    = rd;
      if (mem_write) begin
        if (mem_store_type == ST_DEF) state_d = S_DONE;
        else if (st_mis)              state_d = S_ERR;
        else begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end else if (wb_load) begin
        if (ld_mis) state_d = S_ERR;
        else begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
    end

    case (state_q)
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_req_ready) state_d = st_q ? S_DONE : S_WAIT;
        else if (tmo) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rvalid_eff) begin
          state_d  = S_DONE;
          wbdata_d = load_ext;
        end else if (tmo) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
          drop_d    = 1'b1;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      st_q      <= 1'b0;
      ltype_q   <= '0;
      stype_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      wbdata_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      st_q      <= st_d;
      ltype_q   <= ltype_d;
      stype_q   <= stype_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      wbdata_q  <= wbdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    req_ready      = (state_q == S_IDLE);
    dmem_req_valid = (state_q == S_REQ);
    dmem_addr      = dmem_req_valid ? {addr_q[31:2], 2'b00} : 32'b0;
    dmem_we        = dmem_req_valid && st_q;
    dmem_be        = dmem_we ? lane_be : 4'b0;
    dmem_wdata     = dmem_we ? lane_wdata : 32'b0;
    wb_valid       = (state_q == S_DONE);
    wb_rd          = (wb_valid && !st_q) ? rd_q : 5'b0;
    wb_data        = (wb_valid && !st_q) ? wbdata_q : 32'b0;
    misaligned     = (state_q == S_ERR);
    bus_err        = bus_err_q;
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: driver issues ops and queues expected
// responses/memory requests; a memory responder and an output monitor check them.
module tb_lsu_mem_stage;
  localparam int TMO = 16;
  localparam logic [2:0] K_WB = 3'b001, K_MIS = 3'b010, K_BERR = 3'b100;

  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready;
  logic        mem_write = 0, wb_load = 0;
  logic [2:0]  mem_load_type = 0;
  logic [1:0]  mem_store_type = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic [4:0]  rd = 0;
  logic        dmem_req_valid, dmem_req_ready = 0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned, bus_err;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .wb_load(wb_load), .mem_load_type(mem_load_type),
    .mem_store_type(mem_store_type), .addr(addr), .store_data(store_data), .rd(rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] kind; int cyc; logic [4:0] rd; logic [31:0] data; } sb_t;
  typedef struct { bit ld; int r; int w; logic [31:0] rdata; logic [31:0] addr;
                   logic we; logic [3:0] be; logic [31:0] wdata; } job_t;

  sb_t  sb_q[$];
  job_t mem_q[$];
  bit   mem_busy = 0;
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] lt, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] s;
    byte         b;
    shortint     h;
    s = word >> (8 * a[1:0]);
    b = s[7:0];
    h = s[15:0];
    case (lt)
      3'd0:    return 32'(int'(b));
      3'd1:    return 32'(int'(h));
      3'd3:    return s & 32'hFF;
      3'd4:    return s & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  // Output monitor: every pulse must match the oldest expected response.
  sb_t m;
  always @(negedge clk) begin
    if (!rst && (wb_valid || misaligned || bus_err)) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_pulse: got wb=%0b mis=%0b berr=%0b at cycle %0d, expected none",
                 wb_valid, misaligned, bus_err, cyc);
      end else begin
        m = sb_q.pop_front();
        chk("resp_kind", 64'({bus_err, misaligned, wb_valid}), 64'(m.kind));
        chk("resp_cycle", 64'(cyc), 64'(m.cyc));
        if (m.kind == K_WB) begin
          chk("wb_rd", 64'(wb_rd), 64'(m.rd));
          chk("wb_data", 64'(wb_data), 64'(m.data));
        end
      end
    end
  end

  // Memory responder: ready after r request cycles, rvalid w cycles after handshake.
  job_t j;
  initial begin
    forever begin
      int  i, g;
      bit  hs;
      wait (mem_q.size() > 0);
      j = mem_q.pop_front();
      mem_busy = 1;
      i = 0; g = 0; hs = 0;
      while (!hs && g < 40) begin
        @(negedge clk);
        g++;
        if (dmem_req_valid) begin
          i++;
          if (i == j.r) begin
            dmem_req_ready = 1;
            hs = 1;
            chk("dmem_addr", 64'(dmem_addr), 64'(j.addr));
            chk("dmem_we", 64'(dmem_we), 64'(j.we));
            chk("dmem_be", 64'(dmem_be), 64'(j.be));
            if (j.we) chk("dmem_wdata", 64'(dmem_wdata), 64'(j.wdata));
          end
        end else if (i > 0) g = 40;
      end
      if (hs) begin
        @(negedge clk);
        dmem_req_ready = 0;
        if (j.ld) begin
          for (int k = 1; k < j.w; k++) @(negedge clk);
          dmem_rvalid = 1;
          dmem_rdata  = j.rdata;
          @(negedge clk);
          dmem_rvalid = 0;
          dmem_rdata  = $urandom;
        end
      end
      mem_busy = 0;
    end
  end

  task automatic drain();
    int g = 0;
    while ((sb_q.size() != 0 || mem_q.size() != 0 || mem_busy) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", 64'(g < 400), 64'd1);
    if (g >= 400) begin
      sb_q.delete();
      mem_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input bit mw, input bit wl, input logic [2:0] lt, input logic [1:0] stt,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdn,
                       input int r, input int w, input logic [31:0] word);
    sb_t  e;
    job_t jb;
    int   acc, size;
    bit   has_e, go;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1; mem_write = mw; wb_load = wl; mem_load_type = lt;
    mem_store_type = stt; addr = a; store_data = d; rd = rdn;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 0; mem_write = 1'($urandom); wb_load = 1'($urandom); addr = $urandom;
    store_data = $urandom; rd = 5'($urandom); mem_load_type = 3'($urandom);
    e = '{kind: K_WB, cyc: acc, rd: 5'd0, data: 32'd0};
    jb = '{ld: 0, r: r, w: w, rdata: word, addr: {a[31:2], 2'b00}, we: 0, be: 4'd0, wdata: 32'd0};
    has_e = 0; go = 0;
    if (mw) begin
      has_e = 1;
      if (stt != 2'd3) begin
        size = 1 << stt;
        if ((a[1:0] % size) != 0) e.kind = K_MIS;
        else begin
          go = 1; jb.we = 1;
          case (stt)
            2'd0:    begin jb.be = 4'(1 << a[1:0]); jb.wdata = 32'(d[7:0]) * 32'h01010101; end
            2'd1:    begin jb.be = 4'(3 << a[1:0]); jb.wdata = 32'(d[15:0]) * 32'h00010001; end
            default: begin jb.be = 4'hF; jb.wdata = d; end
          endcase
          if (r > TMO) begin e.kind = K_BERR; e.cyc = acc + TMO; end
          else e.cyc = acc + r;
        end
      end
    end else if (wl) begin
      has_e = 1;
      size = (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd1 || lt == 3'd4) ? 2 : 4;
      if ((a[1:0] % size) != 0) e.kind = K_MIS;
      else begin
        go = 1; jb.ld = 1;
        if (r + w > TMO) begin e.kind = K_BERR; e.cyc = acc + TMO; end
        else begin
          e.cyc = acc + r + w; e.rd = rdn; e.data = ld_model(lt, a, word);
        end
      end
    end
    if (go) mem_q.push_back(jb);
    if (has_e) sb_q.push_back(e);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    job_t rj;
    logic [2:0] lts [6];
    lts = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_dmem_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_pulses", 64'({wb_valid, misaligned, bus_err}), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst = 0;

    issue(1, 0, 0, 2'd0, 32'h1003, 32'hAABBCCDD, 5'd9, 1, 1, 0);
    issue(0, 1, 3'd0, 0, 32'h2001, 0, 5'd3, 1, 4, 32'h123480FF);
    issue(0, 1, 3'd3, 0, 32'h2001, 0, 5'd4, 2, 4, 32'h123480FF);
    issue(0, 1, 3'd1, 0, 32'h2002, 0, 5'd5, 1, 1, 32'h8001ABCD);
    issue(0, 1, 3'd4, 0, 32'h2002, 0, 5'd6, 1, 2, 32'h8001ABCD);
    issue(0, 1, 3'd2, 0, 32'h2000, 0, 5'd7, 3, 1, 32'h8001ABCD);
    issue(0, 1, 3'd1, 0, 32'h2001, 0, 5'd8, 1, 1, 0);
    issue(1, 1, 3'd2, 2'd1, 32'h3002, 32'h1234BEEF, 5'd1, 2, 1, 0);
    issue(1, 0, 0, 2'd3, 32'h3001, 32'h55, 5'd2, 1, 1, 0);
    issue(0, 0, 0, 0, 32'h4000, 0, 5'd2, 1, 1, 0);
    issue(0, 1, 3'd2, 0, 32'h2000, 0, 5'd10, 1, 30, 32'hDEAD0001);
    issue(0, 1, 3'd2, 0, 32'h2004, 0, 5'd11, 1, 2, 32'hCAFE0002);
    issue(0, 1, 3'd7, 0, 32'h2008, 0, 5'd12, 4, 12, 32'h0BADF00D);
    issue(0, 1, 3'd7, 0, 32'h2008, 0, 5'd12, 4, 13, 32'h0BADF00D);
    issue(1, 0, 0, 2'd2, 32'h500C, 32'h01020304, 5'd0, 16, 1, 0);
    issue(1, 0, 0, 2'd2, 32'h500C, 32'h01020304, 5'd0, 17, 1, 0);

    // Reset while a load sits in WAIT: no response, later rvalid ignored.
    @(negedge clk);
    req_valid = 1; mem_write = 0; wb_load = 1; mem_load_type = 3'd2; addr = 32'h6000; rd = 5'd13;
    @(posedge clk);
    #1;
    req_valid = 0;
    rj = '{ld: 1, r: 1, w: 12, rdata: 32'h77777777, addr: 32'h6000, we: 0, be: 4'd0, wdata: 32'd0};
    mem_q.push_back(rj);
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_wait_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_wait_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wait_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 0;
    drain();
    issue(0, 1, 3'd2, 0, 32'h6004, 0, 5'd14, 1, 1, 32'h600D600D);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      int r, w;
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(1, 3);
      w  = $urandom_range(1, 4);
      if ($urandom_range(0, 11) == 0) begin
        r = (op < 3) ? 18 : 1;
        w = 20;
      end
      issue(op < 3, (op >= 3 && op < 7) || (op < 3 && $urandom_range(0, 1) == 1),
            lts[$urandom_range(0, 5)], 2'($urandom), $urandom, $urandom,
            5'($urandom), r, w, $urandom);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
